// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
//   Read-side drain for a sync_fifo. Pops words through the FIFO's registered
//   read port and presents them as a valid/ready stream. A 2-entry output
//   buffer hides the 1-cycle FIFO read latency so a continuously ready
//   consumer receives one word per cycle.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_ni        in   synchronous reset, active-low
//   fifo_re_o     out  FIFO read enable (pop)
//   fifo_data_i   in   FIFO read data, valid one cycle after fifo_re_o
//   fifo_empty_i  in   FIFO empty flag
//   m_valid_o     out  stream word available
//   m_ready_i     in   consumer accepts word
//   m_data_o      out  stream word (buffer head)
//   flush_i       in   discard buffered and in-flight words
//   occupancy_o   out  words held in output buffer (0..2)
//   words_o       out  completed handshake count, wraps at 16 bits
//                      (present only with SYNC_FIFO_READER_STATS_EN)
//
// Optional feature macro: SYNC_FIFO_READER_STATS_EN
//
// state   | meaning
// --------+---------------------------------------
// S_EMPTY | output buffer holds no word
// S_ONE   | head entry valid
// S_TWO   | head and tail entries valid

module sync_fifo_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  fifo_re_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  flush_i,
  output logic [1:0]            occupancy_o
`ifdef SYNC_FIFO_READER_STATS_EN
  ,
  output logic [15:0]           words_o
`endif
);

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    pend_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   head_q, tail_q;
  logic                    pop;
  logic                    capture;
  logic [2:0]              level;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // fifo_re_o is already low during flush, so pend clears with it.
      pend_q  <= fifo_re_o;
      valid_q <= (state_d != S_EMPTY);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (capture) state_d = S_ONE;
        S_ONE: begin
          if (capture && !pop)      state_d = S_TWO;
          else if (pop && !capture) state_d = S_EMPTY;
        end
        S_TWO:   if (pop && !capture) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Output logic
  always_comb begin
    pop     = valid_q & m_ready_i;
    // A word arriving during a flush is dropped.
    capture = pend_q & ~flush_i;
    // Words committed after this edge: buffered + in flight - leaving now.
    // pop implies state_q != S_EMPTY, so this cannot underflow.
    level     = {1'b0, state_q} + {2'b00, pend_q} - {2'b00, pop};
    fifo_re_o = rst_ni & ~fifo_empty_i & ~flush_i & (level < 3'd2);
  end

  assign m_valid_o   = valid_q;
  assign m_data_o    = head_q;
  assign occupancy_o = state_q;

  // Two-entry buffer, head is always the oldest word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush_i) begin
      case ({pop, capture})
        2'b11: begin
          if (state_q == S_TWO) begin
            head_q <= tail_q;
            tail_q <= fifo_data_i;
          end else begin
            head_q <= fifo_data_i;
          end
        end
        2'b10: head_q <= tail_q;
        2'b01: begin
          if (state_q == S_EMPTY) head_q <= fifo_data_i;
          else                    tail_q <= fifo_data_i;
        end
        default: ;
      endcase
    end
  end

`ifdef SYNC_FIFO_READER_STATS_EN
  // Counts every completed handshake, including one taken in a flush cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)  words_o <= 16'h0000;
    else if (pop) words_o <= words_o + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       fifo_re_o;
  logic [7:0] fifo_data_i;
  logic       fifo_empty_i;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       flush_i;
  logic [1:0] occupancy_o;
`ifdef SYNC_FIFO_READER_STATS_EN
  logic [15:0] words_o;
`endif

  int errors = 0;
  int checks = 0;

  // direct drive or FIFO model
  logic       use_model = 1'b0;
  logic       tb_empty  = 1'b1;
  logic [7:0] tb_data   = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] rd = 8'd0;
  logic [7:0] wr = 8'd0;
  logic [7:0] model_data = 8'h00;

  assign fifo_empty_i = use_model ? (rd == wr) : tb_empty;
  assign fifo_data_i  = use_model ? model_data : tb_data;

  always @(posedge clk_i) begin
    if (use_model && fifo_re_o) begin
      model_data <= mem[rd];
      rd         <= rd + 8'd1;
    end
  end

  always #5 clk_i = ~clk_i;

  sync_fifo_reader #(.DATA_WIDTH(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fifo_re_o    (fifo_re_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .flush_i      (flush_i),
    .occupancy_o  (occupancy_o)
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    .words_o      (words_o)
`endif
  );

  typedef struct {
    logic       empty;
    logic [7:0] fdata;
    logic       ready;
    logic       flush;
    logic       exp_re;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut();
    use_model = 1'b0;
    tb_empty  = 1'b1;
    m_ready_i = 1'b0;
    flush_i   = 1'b0;
    rst_ni    = 1'b0;
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr] = d;
    wr = wr + 8'd1;
  endtask

  initial begin
    int first, last, cnt;
    logic [7:0] exp_w;

    //                empty fdata  rdy flush re val data   occ
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[3]  = '{1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2};
    vecs[6]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 2'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[10] = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[13] = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
    vecs[14] = '{1'b0, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 2'd1};
    vecs[15] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 2'd1};
    vecs[16] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

    // reset held 3 cycles with a non-empty FIFO
    rst_ni    = 1'b0;
    m_ready_i = 1'b0;
    flush_i   = 1'b0;
    tb_empty  = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("rst_re", fifo_re_o, 0);
      chk("rst_valid", m_valid_o, 0);
      chk("rst_occ", occupancy_o, 0);
      chk("rst_data", m_data_o, 0);
      next_cycle();
    end
    rst_ni = 1'b1;

    // directed vector table
    for (int i = 0; i < 17; i++) begin
      tb_empty  = vecs[i].empty;
      tb_data   = vecs[i].fdata;
      m_ready_i = vecs[i].ready;
      flush_i   = vecs[i].flush;
      @(negedge clk_i);
      chk($sformatf("vec%0d_re", i), fifo_re_o, vecs[i].exp_re);
      chk($sformatf("vec%0d_valid", i), m_valid_o, vecs[i].exp_valid);
      chk($sformatf("vec%0d_occ", i), occupancy_o, vecs[i].exp_occ);
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), m_data_o, vecs[i].exp_data);
      next_cycle();
    end
    flush_i = 1'b0;

    // single word
    reset_dut();
    push(8'hA5);
    use_model = 1'b1;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("single_re_t0", fifo_re_o, 1);
    chk("single_valid_t0", m_valid_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("single_re_t1", fifo_re_o, 0);
    chk("single_valid_t1", m_valid_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("single_valid_t2", m_valid_o, 1);
    chk("single_data_t2", m_data_o, 8'hA5);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_valid_o && m_ready_i) cnt++;
      next_cycle();
      @(negedge clk_i);
    end
    chk("single_handshakes", cnt, 1);
    chk("single_idle_valid", m_valid_o, 0);

    // streaming 16 words
    reset_dut();
    for (int i = 1; i <= 16; i++) push(8'(i));
    use_model = 1'b1;
    m_ready_i = 1'b1;
    first = -1;
    last  = -1;
    cnt   = 0;
    exp_w = 8'h01;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      chk("stream_re_when_empty", fifo_re_o & fifo_empty_i, 0);
      if (m_valid_o && m_ready_i) begin
        chk("stream_data", m_data_o, exp_w);
        exp_w = exp_w + 8'd1;
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      next_cycle();
    end
    chk("stream_count", cnt, 16);
    chk("stream_first_cycle", first, 2);
    chk("stream_last_cycle", last, 17);

    // backpressure
    reset_dut();
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    use_model = 1'b1;
    m_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (c >= 2) chk("bp_stall_data", m_data_o, 8'hB0);
      if (c >= 3) begin
        chk("bp_occ", occupancy_o, 2);
        chk("bp_re", fifo_re_o, 0);
      end
      next_cycle();
    end
    m_ready_i = 1'b1;
    cnt   = 0;
    exp_w = 8'hB0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        chk("bp_order", m_data_o, exp_w);
        exp_w = exp_w + 8'd1;
        cnt++;
      end
      next_cycle();
    end
    chk("bp_count", cnt, 4);

    // flush with one buffered word and one in flight
    reset_dut();
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    use_model = 1'b1;
    m_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("fl_pre_pop_data", m_data_o, 8'hC0);
    chk("fl_pre_re", fifo_re_o, 1);
    next_cycle();
    m_ready_i = 1'b0;
    flush_i   = 1'b1;
    @(negedge clk_i);
    chk("fl_t_valid", m_valid_o, 1);
    chk("fl_t_data", m_data_o, 8'hC1);
    chk("fl_t_occ", occupancy_o, 1);
    chk("fl_t_re", fifo_re_o, 0);
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("fl_t1_valid", m_valid_o, 0);
    chk("fl_t1_occ", occupancy_o, 0);
    chk("fl_t1_re", fifo_re_o, 1);
    next_cycle();
    @(negedge clk_i);
    chk("fl_t2_valid", m_valid_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("fl_t3_valid", m_valid_o, 1);
    chk("fl_t3_data", m_data_o, 8'hC3);
    next_cycle();
    m_ready_i = 1'b1;
    cnt   = 0;
    exp_w = 8'hC3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (m_valid_o && m_ready_i) begin
        chk("fl_after_order", m_data_o, exp_w);
        exp_w = exp_w + 8'd1;
        cnt++;
      end
      next_cycle();
    end
    chk("fl_after_count", cnt, 3);

`ifdef SYNC_FIFO_READER_STATS_EN
    reset_dut();
    @(negedge clk_i);
    chk("stats_reset", words_o, 16'h0000);
    tb_empty  = 1'b0;
    tb_data   = 8'h5A;
    m_ready_i = 1'b1;
    cnt = 0;
    while (cnt < 70000 && words_o != 16'hFFFF) begin
      next_cycle();
      cnt++;
    end
    chk("stats_preset", words_o, 16'hFFFF);
    next_cycle();
    next_cycle();
    chk("stats_wrap", words_o, 16'h0001);
    m_ready_i = 1'b0;
    tb_empty  = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
